// File: rtl/write_addr_arbiter_if.sv
// AW request / B response bundle between the two write masters, the slaves and the AW arbiter.
// Also holds the route-code macros (`MX_SX_ID_BITS, M*_S*_W, M*_NO_W, AW_IDLE_CODE) shared with the consumers.
`ifndef MX_SX_ID_BITS
`define MX_SX_ID_BITS 4
`endif

// Route code = {master, slave index}; slave index 0 is the default slave (NO).
`ifndef M0_NO_W
`define M0_NO_W   4'h0
`define M0_S1_W   4'h1
`define M0_S2_W   4'h2
`define M0_S3_W   4'h3
`define M0_S4_W   4'h4
`define M0_S5_W   4'h5
`define M1_NO_W   4'h8
`define M1_S1_W   4'h9
`define M1_S2_W   4'hA
`define M1_S3_W   4'hB
`define M1_S4_W   4'hC
`define M1_S5_W   4'hD
`define AW_IDLE_CODE 4'hF
`endif

interface write_addr_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic                      AWVALID_M0;
    logic [ADDR_W-1:0]         AWADDR_M0;
    logic                      AWVALID_M1;
    logic [ADDR_W-1:0]         AWADDR_M1;
    logic [5:0]                AWREADY_S;
    logic                      BVALID_M0;
    logic                      BREADY_M0;
    logic                      BVALID_M1;
    logic                      BREADY_M1;
    logic                      BVALID_S0;
    logic [`MX_SX_ID_BITS-1:0] AW_arbiter;
    logic                      AW_busy;
    logic                      AW_timeout;
    logic [1:0]                state_dbg;

    modport slave (
        input  AWVALID_M0, AWADDR_M0, AWVALID_M1, AWADDR_M1, AWREADY_S,
        input  BVALID_M0, BREADY_M0, BVALID_M1, BREADY_M1, BVALID_S0,
        output AW_arbiter, AW_busy, AW_timeout, state_dbg
    );

    modport master (
        output AWVALID_M0, AWADDR_M0, AWVALID_M1, AWADDR_M1, AWREADY_S,
        output BVALID_M0, BREADY_M0, BVALID_M1, BREADY_M1, BVALID_S0,
        input  AW_arbiter, AW_busy, AW_timeout, state_dbg
    );
endinterface

// File: rtl/write_addr_arbiter.sv
// Round-robin AW arbiter for 2 masters / 6 slaves; holds one grant until its B handshake.
// Optional watchdog release is enabled by defining AW_WDOG_EN.
module write_addr_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int WDOG_CYC = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    write_addr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_RESP = 2'd2} state_t;

    state_t                    state;
    logic [`MX_SX_ID_BITS-1:0] code_q;
    logic                      busy_q;
    logic                      last_m1;
    logic                      grant_m1;
    logic [2:0]                grant_slv;

    logic       win_m1;
    logic [2:0] win_slv;
    logic [7:0] aw_ready_ext;
    logic       aw_hs;
    logic       b_hs;

    function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
        if (a <= ADDR_W'(32'h0000_FFFF))                                    return 3'd1;
        else if (a <= ADDR_W'(32'h0001_FFFF))                               return 3'd2;
        else if (a <= ADDR_W'(32'h0002_FFFF))                               return 3'd3;
        else if (a >= ADDR_W'(32'h1000_0000) && a <= ADDR_W'(32'h1000_03FF)) return 3'd4;
        else if (a >= ADDR_W'(32'h2000_0000) && a <= ADDR_W'(32'h201F_FFFF)) return 3'd5;
        else                                                                 return 3'd0;
    endfunction

    // Handshakes: a transfer happens on an edge where valid and ready are both high;
    // AWVALID/AWADDR are held by the master until then. The default slave's BVALID_S0
    // alone completes a NO grant since that response is never forwarded to a master.
    always_comb begin
        win_m1       = bus.AWVALID_M1 & (~bus.AWVALID_M0 | ~last_m1);
        win_slv      = win_m1 ? decode(bus.AWADDR_M1) : decode(bus.AWADDR_M0);
        aw_ready_ext = {2'b00, bus.AWREADY_S};
        aw_hs        = (grant_m1 ? bus.AWVALID_M1 : bus.AWVALID_M0) & aw_ready_ext[grant_slv];
        if (grant_slv == 3'd0)
            b_hs = bus.BVALID_S0;
        else if (grant_m1)
            b_hs = bus.BVALID_M1 & bus.BREADY_M1;
        else
            b_hs = bus.BVALID_M0 & bus.BREADY_M0;
    end

`ifdef AW_WDOG_EN
    localparam int CNT_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
    logic [CNT_W-1:0] wdog_cnt;
    logic             timeout_q;
`else
    localparam int WDOG_CYC_UNUSED = WDOG_CYC;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= S_IDLE;
            code_q    <= '1;
            busy_q    <= 1'b0;
            last_m1   <= 1'b1;
            grant_m1  <= 1'b0;
            grant_slv <= 3'd0;
`ifdef AW_WDOG_EN
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef AW_WDOG_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.AWVALID_M0 | bus.AWVALID_M1) begin
                        state     <= S_ADDR;
                        grant_m1  <= win_m1;
                        grant_slv <= win_slv;
                        code_q    <= {win_m1, win_slv};
                        busy_q    <= 1'b1;
                        last_m1   <= win_m1;
                    end
                end
                S_ADDR: begin
                    if (aw_hs) state <= S_RESP;
                end
                S_RESP: begin
                    if (b_hs) begin
                        state  <= S_IDLE;
                        code_q <= '1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    code_q <= '1;
                    busy_q <= 1'b0;
                end
            endcase
`ifdef AW_WDOG_EN
            // Counts time spent in the current grant state; expiry overrides any handshake.
            if (state == S_IDLE) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt == CNT_W'(WDOG_CYC - 1)) begin
                state     <= S_IDLE;
                code_q    <= '1;
                busy_q    <= 1'b0;
                timeout_q <= 1'b1;
                wdog_cnt  <= '0;
            end else if (state == S_ADDR && aw_hs) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
`endif
        end
    end

    assign bus.AW_arbiter = code_q;
    assign bus.AW_busy    = busy_q;
    assign bus.state_dbg  = state;
`ifdef AW_WDOG_EN
    assign bus.AW_timeout = timeout_q;
`else
    assign bus.AW_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_write_addr_arbiter.sv
// Directed bench for write_addr_arbiter: grants are checked by a monitor against an expected queue.
module tb_write_addr_arbiter;

    logic ACLK = 1'b0;
    logic ARESETn;

    write_addr_arbiter_if #(.ADDR_W(32)) bus ();

    write_addr_arbiter #(.ADDR_W(32), .WDOG_CYC(1024)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    initial forever #5 ACLK = ~ACLK;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    logic       prev_busy = 1'b0;

    localparam logic [3:0] IDLE_C = 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_b();
        bus.BVALID_M0 = 1'b0;
        bus.BREADY_M0 = 1'b0;
        bus.BVALID_M1 = 1'b0;
        bus.BREADY_M1 = 1'b0;
        bus.BVALID_S0 = 1'b0;
    endtask

    task automatic do_reset();
        bus.AWVALID_M0 = 1'b0;
        bus.AWVALID_M1 = 1'b0;
        bus.AWADDR_M0  = '0;
        bus.AWADDR_M1  = '0;
        bus.AWREADY_S  = '0;
        clear_b();
        ARESETn = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
    endtask

    // Monitor: each new grant (rising AW_busy) must match the oldest expected code.
    always @(negedge ACLK) begin
        if (bus.AW_busy && !prev_busy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got %0h, required no grant", bus.AW_arbiter);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("grant_code", {28'd0, bus.AW_arbiter}, {28'd0, e});
            end
        end
        prev_busy = bus.AW_busy;
    end

    // Called just after the grant edge: probes wrong ready/responses, then completes the write.
    task automatic serve(input int m, input int tgt, input logic [3:0] code);
        bus.AWREADY_S = ~(6'b000001 << tgt);
        tick();
        check("addr_hold_state", bus.state_dbg, 1);
        check("addr_hold_code", bus.AW_arbiter, code);
        bus.AWREADY_S = 6'b000001 << tgt;
        tick();
        check("accept_state", bus.state_dbg, 2);
        bus.AWREADY_S = '0;
        if (m == 0) bus.AWVALID_M0 = 1'b0;
        else        bus.AWVALID_M1 = 1'b0;
        if (tgt == 0) begin
            bus.BVALID_M0 = 1'b1; bus.BREADY_M0 = 1'b1;
            bus.BVALID_M1 = 1'b1; bus.BREADY_M1 = 1'b1;
        end else begin
            bus.BVALID_S0 = 1'b1;
            if (m == 0) begin
                bus.BVALID_M0 = 1'b1;
                bus.BVALID_M1 = 1'b1; bus.BREADY_M1 = 1'b1;
            end else begin
                bus.BVALID_M1 = 1'b1;
                bus.BVALID_M0 = 1'b1; bus.BREADY_M0 = 1'b1;
            end
        end
        tick();
        clear_b();
        check("resp_hold_busy", bus.AW_busy, 1);
        check("resp_hold_code", bus.AW_arbiter, code);
        if (tgt == 0) bus.BVALID_S0 = 1'b1;
        else if (m == 0) begin bus.BVALID_M0 = 1'b1; bus.BREADY_M0 = 1'b1; end
        else begin bus.BVALID_M1 = 1'b1; bus.BREADY_M1 = 1'b1; end
        tick();
        clear_b();
        check("release_code", bus.AW_arbiter, IDLE_C);
        check("release_busy", bus.AW_busy, 0);
        check("release_state", bus.state_dbg, 0);
    endtask

    logic [31:0] t_addr[10] = '{32'h0000_FFFF, 32'h0001_0000, 32'h0002_FFFF, 32'h0003_0000,
                                32'h1000_03FF, 32'h1000_0400, 32'h201F_FFFF, 32'h2020_0000,
                                32'h0FFF_FFFF, 32'h2000_0000};
    int          t_tgt[10]  = '{1, 2, 3, 0, 4, 0, 5, 0, 0, 5};
    logic [3:0]  t_code[10] = '{4'h1, 4'hA, 4'h3, 4'h8, 4'h4, 4'h8, 4'h5, 4'h8, 4'h0, 4'hD};

    initial begin
        do_reset();
        check("reset_code", bus.AW_arbiter, IDLE_C);
        check("reset_busy", bus.AW_busy, 0);
        check("reset_timeout", bus.AW_timeout, 0);
        check("reset_state", bus.state_dbg, 0);

        // Reset asserted while a grant sits in RESP
        bus.AWVALID_M0 = 1'b1;
        bus.AWADDR_M0  = 32'h0000_0010;
        exp_q.push_back(4'h1);
        tick();
        bus.AWREADY_S = 6'b000010;
        tick();
        bus.AWREADY_S  = '0;
        bus.AWVALID_M0 = 1'b0;
        check("pre_reset_state", bus.state_dbg, 2);
        #2;
        ARESETn = 1'b0;
        #1;
        check("async_reset_code", bus.AW_arbiter, IDLE_C);
        check("async_reset_busy", bus.AW_busy, 0);
        check("async_reset_state", bus.state_dbg, 0);
        tick();
        ARESETn = 1'b1;
        tick();

        // M0 single write to S2, latency and address-change immunity
        bus.AWVALID_M0 = 1'b1;
        bus.AWADDR_M0  = 32'h0001_0040;
        exp_q.push_back(4'h2);
        #2;
        check("no_comb_path", bus.AW_arbiter, IDLE_C);
        tick();
        check("m0_s2_code", bus.AW_arbiter, 4'h2);
        check("m0_s2_busy", bus.AW_busy, 1);
        bus.AWADDR_M0 = 32'h2000_0000;
        tick();
        check("addr_change_hold", bus.AW_arbiter, 4'h2);
        bus.AWADDR_M0 = 32'h0001_0040;
        serve(0, 2, 4'h2);

        // Tie after reset: M0 first, IDLE gap, then M1
        do_reset();
        bus.AWVALID_M0 = 1'b1; bus.AWADDR_M0 = 32'h0000_0010;
        bus.AWVALID_M1 = 1'b1; bus.AWADDR_M1 = 32'h1000_0000;
        exp_q.push_back(4'h1);
        exp_q.push_back(4'hC);
        tick();
        serve(0, 1, 4'h1);
        tick();
        check("tie_second_code", bus.AW_arbiter, 4'hC);
        serve(1, 4, 4'hC);

        // Fairness under continuous requests
        do_reset();
        bus.AWVALID_M0 = 1'b1; bus.AWADDR_M0 = 32'h0000_0010;
        bus.AWVALID_M1 = 1'b1; bus.AWADDR_M1 = 32'h2000_0000;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back((i % 2 == 0) ? 4'h1 : 4'hD);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0) begin
                serve(0, 1, 4'h1);
                bus.AWVALID_M0 = 1'b1;
            end else begin
                serve(1, 5, 4'hD);
                bus.AWVALID_M1 = 1'b1;
            end
        end
        bus.AWVALID_M0 = 1'b0;
        bus.AWVALID_M1 = 1'b0;
        tick();

        // Unmapped address from M1 goes to the default slave
        bus.AWVALID_M1 = 1'b1;
        bus.AWADDR_M1  = 32'h3000_0000;
        exp_q.push_back(4'h8);
        tick();
        serve(1, 0, 4'h8);

        // Address map boundaries, alternating masters
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin bus.AWVALID_M0 = 1'b1; bus.AWADDR_M0 = t_addr[i]; end
            else            begin bus.AWVALID_M1 = 1'b1; bus.AWADDR_M1 = t_addr[i]; end
            exp_q.push_back(t_code[i]);
            tick();
            serve(i % 2, t_tgt[i], t_code[i]);
        end

        tick();
        check("end_timeout", bus.AW_timeout, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
